seg7_scan_595: RTL and testbench

SEG7_SCAN_595 -- requirements
Module: seg7_scan_595

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_scan_595_encode.sv | 19 +
 rtl/seg7_scan_595.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_595.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, segment lookup table and FSM state type for the 595 display scanner.
package seg7_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd10;
    localparam logic [CODE_W-1:0] CODE_MINUS = 4'd11;

    // Segment patterns {dp,g,f,e,d,c,b,a}; dp bit is always 0 here and merged later.
    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DWELL = 2'd3
    } state_e;

endpackage

// File: rtl/seg7_scan_595_encode.sv
// Combinational code-to-segment decode with decimal point and blanking.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic              dp_i,
    input  logic              blank_i,
    output logic [SEG_W-1:0]  seg_o
);

    // Blanking clears every segment including the decimal point.
    always_comb begin
        seg_o = '0;
        if (!blank_i) begin
            seg_o = {dp_i, SEG_LUT[code_i][SEG_W-2:0]};
        end
    end

endmodule

// File: rtl/seg7_scan_595.sv
// Multiplexed 7-segment scanner driving a pair of daisy-chained 74HC595 shift registers.
module seg7_scan_595
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 64,
    parameter int unsigned BLINK_BITS   = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    colon_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic                    sclk_o,
    output logic                    data_o,
    output logic                    latch_en_o,
    output logic                    frame_o
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned BIT_W = $clog2(2 * WORD_W);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DW_W-1:0]  LAST_DW   = DW_W'(DWELL_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(2 * WORD_W - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLINK_BITS-1:0]   frame_cnt_q, frame_cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DW_W-1:0]         dwell_q, dwell_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic                    sclk_q, sclk_d;
    logic                    data_q, data_d;
    logic                    latch_q, latch_d;
    logic                    frame_q, frame_d;

    logic [SEG_W-1:0]        seg_c;
    logic [SEG_W-1:0]        dig_c;
    logic                    blank_c;

    assign blank_c = frame_cnt_q[BLINK_BITS-1] & blink_mask_i[idx_q];

    seg7_encode u_encode (
        .code_i  (digits_i[{idx_q, 2'b00} +: CODE_W]),
        .dp_i    (dp_i[idx_q]),
        .blank_i (blank_c),
        .seg_o   (seg_c)
    );

    // Digit byte: active-low select for the current digit, unused selects high, colon on top.
    always_comb begin
        dig_c = '1;
        for (int unsigned k = 0; k < 7; k++) begin
            if (k < NUM_DIGITS) begin
                dig_c[k] = (IDX_W'(k) != idx_q);
            end
        end
        dig_c[7] = colon_i;
    end

    // Next-state and registered-output logic; outputs default low outside SHIFT/LATCH.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        bit_d       = bit_q;
        dwell_d     = dwell_q;
        word_d      = word_q;
        sclk_d      = 1'b0;
        data_d      = 1'b0;
        latch_d     = 1'b0;
        frame_d     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                word_d  = {dig_c, seg_c};
                bit_d   = '0;
                data_d  = dig_c[7];
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_q == LAST_BIT) begin
                    bit_d   = '0;
                    latch_d = 1'b1;
                    state_d = ST_LATCH;
                    if (idx_q == LAST_IDX) begin
                        frame_d     = 1'b1;
                        frame_cnt_d = BLINK_BITS'(frame_cnt_q + 1'b1);
                    end
                end else begin
                    bit_d  = BIT_W'(bit_q + 1'b1);
                    sclk_d = bit_d[0];
                    // Two cycles per bit, MSB first: bit index 15 - (bit_d/2).
                    data_d = word_q[~bit_d[BIT_W-1:1]];
                end
            end
            ST_LATCH: begin
                dwell_d = '0;
                state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (dwell_q == LAST_DW) begin
                    dwell_d = '0;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : IDX_W'(idx_q + 1'b1);
                    state_d = ST_LOAD;
                end else begin
                    dwell_d = DW_W'(dwell_q + 1'b1);
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            bit_q       <= '0;
            dwell_q     <= '0;
            word_q      <= '0;
            sclk_q      <= 1'b0;
            data_q      <= 1'b0;
            latch_q     <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            bit_q       <= bit_d;
            dwell_q     <= dwell_d;
            word_q      <= word_d;
            sclk_q      <= sclk_d;
            data_q      <= data_d;
            latch_q     <= latch_d;
            frame_q     <= frame_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign data_o     = data_q;
    assign latch_en_o = latch_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg7_scan_595.sv
// Directed bench for seg7_scan_595: decodes the serial stream back into latched words.
module tb_seg7_scan_595;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 5;
    localparam int unsigned PERIOD = 34 + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   digits = '0;
    logic [ND-1:0] dp = '0;
    logic          colon = 1'b0;
    logic [ND-1:0] mask = '0;
    logic          sclk, sdata, latch, frame;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] wq[$];
    int          lc[$];
    logic        fq[$];
    int          rq[$];

    seg7_scan_595 #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLINK_BITS(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .digits_i     (digits),
        .dp_i         (dp),
        .colon_i      (colon),
        .blink_mask_i (mask),
        .sclk_o       (sclk),
        .data_o       (sdata),
        .latch_en_o   (latch),
        .frame_o      (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: shifts data on sclk rises, records each latched word.
    int          cyc = 0;
    logic [15:0] sh = '0;
    int          rises = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_data = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sh = '0;
            rises = 0;
            prev_sclk = 1'b0;
            prev_data = 1'b0;
        end else begin
            if (sclk) chk("data_stable", 32'(sdata), 32'(prev_data));
            if (sclk && !prev_sclk) begin
                sh = {sh[14:0], sdata};
                rises++;
            end
            if (frame && !latch) chk("frame_without_latch", 32'(frame), 32'd0);
            if (latch) begin
                chk("sclk_in_latch", 32'(sclk), 32'd0);
                wq.push_back(sh);
                lc.push_back(cyc);
                fq.push_back(frame);
                rq.push_back(rises);
                rises = 0;
            end
            prev_sclk = sclk;
            prev_data = sdata;
        end
    end

    task automatic clear_q();
        wq.delete(); lc.delete(); fq.delete(); rq.delete();
    endtask

    task automatic restart(input logic [15:0] d, input logic [ND-1:0] p,
                           input logic c, input logic [ND-1:0] m);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        digits = d; dp = p; colon = c; mask = m;
        #1 clear_q();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (wq.size() < n && t < PERIOD * n + 50) begin
            @(negedge clk);
            #1 t++;
        end
        if (wq.size() < n) chk("timeout_words", 32'(wq.size()), 32'(n));
    endtask

    logic [15:0] exp_a[4] = '{16'h7E06, 16'h7D5B, 16'h7B4F, 16'h7766};
    logic [15:0] exp_d[9] = '{16'h7E7F, 16'h7D7F, 16'h7B7F, 16'h777F,
                              16'h7E00, 16'h7D7F, 16'h7B7F, 16'h777F, 16'h7E7F};
    logic [3:0]  codes[3] = '{4'd10, 4'd11, 4'd15};
    logic [7:0]  segs[3]  = '{8'h00, 8'h40, 8'h00};

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sclk",  32'(sclk),  32'd0);
        chk("rst_data",  32'(sdata), 32'd0);
        chk("rst_latch", 32'(latch), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);

        // Plain digits 1,2,3,4 over two frames
        restart(16'h4321, 4'b0000, 1'b0, 4'b0000);
        wait_words(8);
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            chk($sformatf("word_a%0d", i), 32'(wq[i]), 32'(exp_a[i % 4]));
            chk($sformatf("frame_a%0d", i), 32'(fq[i]), 32'((i % 4) == 3));
            // 16 bits, two SHIFT cycles each -> one sclk rise per bit
            chk($sformatf("rises_a%0d", i), 32'(rq[i]), 32'd16);
            if (i > 0) chk($sformatf("spacing_a%0d", i), 32'(lc[i] - lc[i-1]), 32'(PERIOD));
        end

        // Full segments, decimal point and colon on digit 0
        restart(16'h0008, 4'b0001, 1'b1, 4'b0000);
        wait_words(1);
        if (wq.size() > 0) chk("word_dp_colon", 32'(wq[0]), 32'hFEFF);

        // Blank, minus and out-of-range codes
        for (int i = 0; i < 3; i++) begin
            restart({12'h000, codes[i]}, 4'b0000, 1'b0, 4'b0000);
            wait_words(1);
            if (wq.size() > 0) begin
                chk($sformatf("seg_code%0d", codes[i]), 32'(wq[0][7:0]), 32'(segs[i]));
                chk($sformatf("dig_code%0d", codes[i]), 32'(wq[0][15:8]), 32'h7E);
            end
        end

        // Blink on digit 0 with a one-bit frame counter
        restart(16'h8888, 4'b0000, 1'b0, 4'b0001);
        wait_words(9);
        for (int i = 0; i < 9 && i < wq.size(); i++)
            chk($sformatf("word_blink%0d", i), 32'(wq[i]), 32'(exp_d[i]));

        // Input change mid-SHIFT is ignored until the next LOAD
        restart(16'h4321, 4'b0000, 1'b0, 4'b0000);
        wait_words(1);
        repeat (10) @(negedge clk);
        digits = 16'h9999;
        wait_words(2);
        if (wq.size() > 1) chk("word_midshift_hold", 32'(wq[1]), 32'h7D5B);
        wait_words(3);
        if (wq.size() > 2) chk("word_midshift_take", 32'(wq[2]), 32'h7B6F);

        // Reset asserted on the 10th SHIFT cycle of digit 2
        restart(16'h4321, 4'b0000, 1'b0, 4'b0000);
        wait_words(2);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #1;
        chk("shift10_sclk", 32'(sclk), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_sclk",  32'(sclk),  32'd0);
        chk("abort_data",  32'(sdata), 32'd0);
        chk("abort_latch", 32'(latch), 32'd0);
        chk("abort_frame", 32'(frame), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_latch", 32'(wq.size()), 32'd2);
        rst = 1'b0;
        wait_words(3);
        if (wq.size() > 2) begin
            chk("after_abort_word", 32'(wq[2]), 32'h7E06);
            chk("after_abort_rises", 32'(rq[2]), 32'd16);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
